// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger path.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alarm_state_e;

  localparam int unsigned BCD_W = 8;
  localparam logic [BCD_W-1:0] BCD_ZERO = 8'h00;

endpackage

// File: rtl/button_edge.sv
// Registers a debounced button level and emits a one-cycle registered press pulse on its rising edge.
module button_edge (
  input  logic s_clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic hist_q, hist_d;
  logic press_q, press_d;

  always_comb begin
    hist_d  = btn;
    press_d = btn & ~hist_q;
  end

  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      hist_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alarm_trigger_controller.sv
// Compares BCD time against the alarm on each tick and runs the ring/snooze/stop machine.
module alarm_trigger_controller
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_SECONDS = 300,
  parameter int unsigned RING_TIMEOUT   = 60,
  parameter int unsigned MAX_SNOOZES    = 3
) (
  input  logic             s_clock,
  input  logic             reset,
  input  logic             tick,
  input  logic [BCD_W-1:0] time_hh,
  input  logic [BCD_W-1:0] time_mm,
  input  logic [BCD_W-1:0] time_ss,
  input  logic [BCD_W-1:0] alarm_hh,
  input  logic [BCD_W-1:0] alarm_mm,
  input  logic             alarm_enable,
  input  logic             snooze_btn,
  input  logic             stop_btn,
  output logic             buzzer,
  output logic             ringing,
  output logic             snoozing,
  output logic [9:0]       snooze_left,
  output logic [2:0]       snooze_count
);

  localparam int unsigned RING_W = 8;
  localparam int unsigned LEFT_W = 10;
  localparam int unsigned CNT_W  = 3;

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT - 1);
  localparam logic [LEFT_W-1:0] SNOOZE_INIT = LEFT_W'(SNOOZE_SECONDS);
  localparam logic [CNT_W-1:0]  SNOOZE_MAX = CNT_W'(MAX_SNOOZES);

  alarm_state_e      state_q, state_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [LEFT_W-1:0] snooze_left_q, snooze_left_d;
  logic [CNT_W-1:0]  snooze_count_q, snooze_count_d;
  logic              beep_q, beep_d;

  logic snooze_press;
  logic stop_press;
  logic match_c;

  button_edge u_snooze_edge (
    .s_clock (s_clock),
    .reset   (reset),
    .btn     (snooze_btn),
    .press   (snooze_press)
  );

  button_edge u_stop_edge (
    .s_clock (s_clock),
    .reset   (reset),
    .btn     (stop_btn),
    .press   (stop_press)
  );

  // Seconds must be zero so a minute-long match produces exactly one event.
  assign match_c = tick & (time_hh == alarm_hh) & (time_mm == alarm_mm) & (time_ss == BCD_ZERO);

  always_comb begin
    state_d        = state_q;
    ring_cnt_d     = ring_cnt_q;
    snooze_left_d  = snooze_left_q;
    snooze_count_d = snooze_count_q;
    beep_d         = beep_q;

    case (state_q)
      ST_IDLE: begin
        ring_cnt_d    = '0;
        snooze_left_d = '0;
        beep_d        = 1'b0;
        if (alarm_enable && match_c) begin
          state_d        = ST_RINGING;
          snooze_count_d = '0;
          beep_d         = 1'b1;
        end
      end

      ST_RINGING: begin
        if (!alarm_enable || stop_press) begin
          state_d       = ST_IDLE;
          ring_cnt_d    = '0;
          snooze_left_d = '0;
          beep_d        = 1'b0;
        end else if (snooze_press && (snooze_count_q < SNOOZE_MAX)) begin
          state_d        = ST_SNOOZE;
          snooze_left_d  = SNOOZE_INIT;
          snooze_count_d = snooze_count_q + CNT_W'(1);
        end else if (tick) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d       = ST_IDLE;
            ring_cnt_d    = '0;
            snooze_left_d = '0;
            beep_d        = 1'b0;
          end else begin
            ring_cnt_d = ring_cnt_q + RING_W'(1);
            beep_d     = ~beep_q;
          end
        end
      end

      ST_SNOOZE: begin
        // Snooze presses fall through here and are ignored.
        if (!alarm_enable || stop_press) begin
          state_d       = ST_IDLE;
          ring_cnt_d    = '0;
          snooze_left_d = '0;
          beep_d        = 1'b0;
        end else if (tick) begin
          if (snooze_left_q == LEFT_W'(1)) begin
            state_d       = ST_RINGING;
            ring_cnt_d    = '0;
            snooze_left_d = '0;
            beep_d        = 1'b1;
          end else begin
            snooze_left_d = snooze_left_q - LEFT_W'(1);
          end
        end
      end

      default: begin
        state_d       = ST_IDLE;
        ring_cnt_d    = '0;
        snooze_left_d = '0;
        beep_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ring_cnt_q     <= '0;
      snooze_left_q  <= '0;
      snooze_count_q <= '0;
      beep_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      snooze_left_q  <= snooze_left_d;
      snooze_count_q <= snooze_count_d;
      beep_q         <= beep_d;
    end
  end

  assign ringing      = (state_q == ST_RINGING);
  assign snoozing     = (state_q == ST_SNOOZE);
  assign buzzer       = ringing & beep_q;
  assign snooze_left  = snooze_left_q;
  assign snooze_count = snooze_count_q;

endmodule

// File: tb/tb_alarm_trigger_controller.sv
// Directed vector bench for alarm_trigger_controller with short timeout/snooze parameters.
module tb_alarm_trigger_controller;

  logic       s_clock;
  logic       reset;
  logic       tick;
  logic [7:0] time_hh, time_mm, time_ss;
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_enable;
  logic       snooze_btn, stop_btn;
  logic       buzzer, ringing, snoozing;
  logic [9:0] snooze_left;
  logic [2:0] snooze_count;

  int checks;
  int failures;

  alarm_trigger_controller #(
    .SNOOZE_SECONDS (3),
    .RING_TIMEOUT   (4),
    .MAX_SNOOZES    (2)
  ) dut (
    .s_clock      (s_clock),
    .reset        (reset),
    .tick         (tick),
    .time_hh      (time_hh),
    .time_mm      (time_mm),
    .time_ss      (time_ss),
    .alarm_hh     (alarm_hh),
    .alarm_mm     (alarm_mm),
    .alarm_enable (alarm_enable),
    .snooze_btn   (snooze_btn),
    .stop_btn     (stop_btn),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_left  (snooze_left),
    .snooze_count (snooze_count)
  );

  initial s_clock = 1'b0;
  always #5 s_clock = ~s_clock;

  // tm: 0 = 12:00:05, 1 = 07:30:00 (match), 2 = 07:30:01
  typedef struct {
    logic       tk;
    logic [1:0] tm;
    logic       en;
    logic       sn;
    logic       sp;
    logic       r;
    logic       s;
    logic       bz;
    logic [9:0] left;
    logic [2:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic tk, input logic [1:0] tm, input logic en, input logic sn,
                     input logic sp, input logic r, input logic s, input logic bz,
                     input logic [9:0] left, input logic [2:0] cnt);
    vec_t v;
    v.tk = tk; v.tm = tm; v.en = en; v.sn = sn; v.sp = sp;
    v.r = r; v.s = s; v.bz = bz; v.left = left; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic set_time(input logic [1:0] tm);
    case (tm)
      2'd1:    begin time_hh = 8'h07; time_mm = 8'h30; time_ss = 8'h00; end
      2'd2:    begin time_hh = 8'h07; time_mm = 8'h30; time_ss = 8'h01; end
      default: begin time_hh = 8'h12; time_mm = 8'h00; time_ss = 8'h05; end
    endcase
  endtask

  task automatic check(input string name, input logic r, input logic s, input logic bz,
                       input logic [9:0] left, input logic [2:0] cnt);
    logic [15:0] act, exp;
    act = {ringing, snoozing, buzzer, snooze_left, snooze_count};
    exp = {r, s, bz, left, cnt};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual ring=%b snz=%b buz=%b left=%0d cnt=%0d required ring=%b snz=%b buz=%b left=%0d cnt=%0d",
               name, ringing, snoozing, buzzer, snooze_left, snooze_count, r, s, bz, left, cnt);
    end
  endtask

  task automatic step(input logic tk, input logic [1:0] tm, input logic en,
                      input logic sn, input logic sp);
    @(negedge s_clock);
    tick = tk; set_time(tm); alarm_enable = en; snooze_btn = sn; stop_btn = sp;
    @(posedge s_clock);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    tick = 1'b0;
    alarm_hh = 8'h07;
    alarm_mm = 8'h30;
    alarm_enable = 1'b1;
    snooze_btn = 1'b0;
    stop_btn = 1'b0;
    set_time(2'd0);

    //  tk tm en sn sp | r  s  bz left cnt
    add(0, 0, 1, 0, 0,   0, 0, 0, 0, 0);  // idle
    add(0, 1, 1, 0, 0,   0, 0, 0, 0, 0);  // match time without tick
    add(1, 2, 1, 0, 0,   0, 0, 0, 0, 0);  // seconds non-zero
    add(1, 1, 1, 0, 0,   1, 0, 1, 0, 0);  // trigger
    add(1, 0, 1, 0, 0,   1, 0, 0, 0, 0);  // tick 1
    add(1, 1, 1, 0, 0,   1, 0, 1, 0, 0);  // tick 2, match ignored
    add(1, 0, 1, 0, 0,   1, 0, 0, 0, 0);  // tick 3
    add(1, 0, 1, 0, 0,   0, 0, 0, 0, 0);  // tick 4 timeout
    add(1, 1, 1, 0, 0,   1, 0, 1, 0, 0);  // trigger
    add(0, 0, 1, 1, 0,   1, 0, 1, 0, 0);  // snooze registered
    add(0, 0, 1, 0, 0,   0, 1, 0, 3, 1);  // snooze 1
    add(1, 0, 1, 0, 0,   0, 1, 0, 2, 1);
    add(1, 0, 1, 1, 0,   0, 1, 0, 1, 1);
    add(0, 0, 1, 0, 0,   0, 1, 0, 1, 1);  // snooze press in SNOOZE ignored
    add(1, 0, 1, 0, 0,   1, 0, 1, 0, 1);  // snooze expired
    add(0, 0, 1, 1, 0,   1, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0,   0, 1, 0, 3, 2);  // snooze 2
    add(1, 0, 1, 0, 0,   0, 1, 0, 2, 2);
    add(1, 0, 1, 0, 0,   0, 1, 0, 1, 2);
    add(1, 0, 1, 0, 0,   1, 0, 1, 0, 2);
    add(0, 0, 1, 1, 0,   1, 0, 1, 0, 2);
    add(0, 0, 1, 0, 0,   1, 0, 1, 0, 2);  // third snooze ignored
    add(1, 0, 1, 0, 0,   1, 0, 0, 0, 2);
    add(0, 0, 1, 1, 1,   1, 0, 0, 0, 2);
    add(0, 0, 1, 0, 0,   0, 0, 0, 0, 2);  // stop, count held
    add(1, 1, 1, 0, 0,   1, 0, 1, 0, 0);  // new event clears count
    add(0, 0, 1, 1, 1,   1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0,   0, 0, 0, 0, 0);  // stop wins over snooze
    add(1, 1, 1, 0, 0,   1, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0,   1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1, 0, 3, 1);
    add(1, 0, 1, 0, 0,   0, 1, 0, 2, 1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 1);  // disable in SNOOZE
    add(1, 1, 0, 0, 0,   0, 0, 0, 0, 1);  // disabled, no trigger
    add(1, 1, 1, 0, 0,   1, 0, 1, 0, 0);  // re-enabled trigger

    #2;
    check("reset_state", 0, 0, 0, 0, 0);
    @(negedge s_clock);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].tk, vq[i].tm, vq[i].en, vq[i].sn, vq[i].sp);
      check($sformatf("vec%0d", i), vq[i].r, vq[i].s, vq[i].bz, vq[i].left, vq[i].cnt);
    end

    // Async reset mid-ring with snooze held across it.
    @(negedge s_clock);
    tick = 1'b0; set_time(2'd0); snooze_btn = 1'b1;
    #2 reset = 1'b1;
    #1 check("async_reset", 0, 0, 0, 0, 0);
    @(negedge s_clock);
    reset = 1'b0;
    step(0, 0, 1, 1, 0);
    check("post_reset_idle", 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    check("post_reset_trigger", 1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    check("held_btn_no_press", 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    check("final_stop", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
